// File: rtl/axil_sram_bridge.sv
// AXI4-Lite slave bridging reads and writes onto a single-port SRAM with done strobes.
// Read/write arbitration alternates on ties; addresses outside the base window get SLVERR.
module axil_sram_bridge #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                SRAM_AW   = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [DATA_W-1:0]    s_axi_wdata,
  input  logic [DATA_W/8-1:0]  s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic                 s_axi_bvalid,
  output logic [1:0]           s_axi_bresp,
  input  logic                 s_axi_bready,
  input  logic [ADDR_W-1:0]    s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic                 s_axi_rvalid,
  output logic [DATA_W-1:0]    s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  input  logic                 s_axi_rready,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  output logic [DATA_W/8-1:0]  sram_be,
  output logic                 sram_wr_en,
  output logic                 sram_rd_en,
  input  logic [DATA_W-1:0]    sram_rdata,
  input  logic                 sram_wr_done,
  input  logic                 sram_rd_done
);

  localparam int STRB_W = DATA_W / 8;
  localparam int ALSB   = (DATA_W == 64) ? 3 : 2;
  localparam int HI     = ALSB + SRAM_AW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACC  = 3'd1,
    RD_ACC  = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  state_t              state_q;
  grant_t              last_grant_q;
  logic                ready_q;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic                ar_held_q, ar_held_d;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                bvalid_q, rvalid_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [SRAM_AW-1:0]  sram_addr_q;
  logic [DATA_W-1:0]   sram_wdata_q;
  logic [STRB_W-1:0]   sram_be_q;
  logic                sram_wr_en_q, sram_rd_en_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic wr_pend, rd_pend, pick_wr;
  logic aw_in_win, ar_in_win;
  logic unused_addr_lsbs;

  assign s_axi_awready = ready_q & ~aw_held_q;
  assign s_axi_wready  = ready_q & ~w_held_q;
  assign s_axi_arready = ready_q & ~ar_held_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign sram_addr     = sram_addr_q;
  assign sram_wdata    = sram_wdata_q;
  assign sram_be       = sram_be_q;
  assign sram_wr_en    = sram_wr_en_q;
  assign sram_rd_en    = sram_rd_en_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign b_hs  = bvalid_q & s_axi_bready;
  assign r_hs  = rvalid_q & s_axi_rready;

  assign aw_in_win = (awaddr_q[ADDR_W-1:HI] == BASE_ADDR[ADDR_W-1:HI]);
  assign ar_in_win = (araddr_q[ADDR_W-1:HI] == BASE_ADDR[ADDR_W-1:HI]);
  assign unused_addr_lsbs = ^{awaddr_q[ALSB-1:0], araddr_q[ALSB-1:0]};

  assign wr_pend = aw_held_q & w_held_q;
  assign rd_pend = ar_held_q;
  // On a tie the direction not served last wins, so after reset a write goes first.
  assign pick_wr = wr_pend & (~rd_pend | (last_grant_q == GRANT_RD));

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    ar_held_d = ar_held_q;
    if (aw_hs) aw_held_d = 1'b1;
    if (w_hs)  w_held_d  = 1'b1;
    if (ar_hs) ar_held_d = 1'b1;
    if (b_hs) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    if (r_hs) ar_held_d = 1'b0;
  end

  // Channel holding registers; ready_q keeps all readys low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      ready_q   <= 1'b1;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      ar_held_q <= ar_held_d;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (ar_hs) araddr_q <= s_axi_araddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_RD;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_be_q    <= '0;
      sram_wr_en_q <= 1'b0;
      sram_rd_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_wr) begin
            if (!aw_in_win) begin
              bresp_q  <= RESP_SLVERR;
              bvalid_q <= 1'b1;
              state_q  <= WR_RESP;
            end else if (wstrb_q == '0) begin
              bresp_q  <= RESP_OKAY;
              bvalid_q <= 1'b1;
              state_q  <= WR_RESP;
            end else begin
              sram_addr_q  <= awaddr_q[HI-1:ALSB];
              sram_wdata_q <= wdata_q;
              sram_be_q    <= wstrb_q;
              sram_wr_en_q <= 1'b1;
              state_q      <= WR_ACC;
            end
          end else if (rd_pend) begin
            if (!ar_in_win) begin
              rresp_q  <= RESP_SLVERR;
              rdata_q  <= '0;
              rvalid_q <= 1'b1;
              state_q  <= RD_RESP;
            end else begin
              sram_addr_q  <= araddr_q[HI-1:ALSB];
              sram_rd_en_q <= 1'b1;
              state_q      <= RD_ACC;
            end
          end
        end
        WR_ACC: begin
          if (sram_wr_done) begin
            sram_wr_en_q <= 1'b0;
            bresp_q      <= RESP_OKAY;
            bvalid_q     <= 1'b1;
            state_q      <= WR_RESP;
          end
        end
        RD_ACC: begin
          if (sram_rd_done) begin
            sram_rd_en_q <= 1'b0;
            rdata_q      <= sram_rdata;
            rresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b1;
            state_q      <= RD_RESP;
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            bvalid_q     <= 1'b0;
            last_grant_q <= GRANT_WR;
            state_q      <= IDLE;
          end
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            rvalid_q     <= 1'b0;
            last_grant_q <= GRANT_RD;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_sram_bridge.sv
// Directed bench for axil_sram_bridge: a behavioural SRAM with programmable wait states,
// response queues checked by a negedge monitor, and cycle-accurate latency probes.
module tb_axil_sram_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int SRAM_AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ADDR_W-1:0]  awaddr = '0;
  logic               awvalid = 1'b0, awready;
  logic [DATA_W-1:0]  wdata = '0;
  logic [STRB_W-1:0]  wstrb = '0;
  logic               wvalid = 1'b0, wready;
  logic               bvalid, bready = 1'b1;
  logic [1:0]         bresp;
  logic [ADDR_W-1:0]  araddr = '0;
  logic               arvalid = 1'b0, arready;
  logic               rvalid, rready = 1'b1;
  logic [DATA_W-1:0]  rdata;
  logic [1:0]         rresp;
  logic [SRAM_AW-1:0] sramAddr;
  logic [DATA_W-1:0]  sramWdata, sramRdata;
  logic [STRB_W-1:0]  sramBe;
  logic               sramWrEn, sramRdEn, sramWrDone, sramRdDone;

  always #5 clk = ~clk;

  axil_sram_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_AW(SRAM_AW), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bvalid(bvalid), .s_axi_bresp(bresp), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rvalid(rvalid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rready(rready),
    .sram_addr(sramAddr), .sram_wdata(sramWdata), .sram_be(sramBe),
    .sram_wr_en(sramWrEn), .sram_rd_en(sramRdEn), .sram_rdata(sramRdata),
    .sram_wr_done(sramWrDone), .sram_rd_done(sramRdDone)
  );

  // Behavioural SRAM: done rises after waitCfg cycles of an asserted enable.
  logic [DATA_W-1:0] mem [0:(1<<SRAM_AW)-1];
  int waitCfg = 0;
  int waitCnt = 0;
  int enCycles = 0;

  function automatic logic [DATA_W-1:0] mergeBytes(input logic [DATA_W-1:0] oldW,
                                                   input logic [DATA_W-1:0] newW,
                                                   input logic [STRB_W-1:0] be);
    logic [DATA_W-1:0] res;
    res = oldW;
    for (int b = 0; b < STRB_W; b++) if (be[b]) res[b*8 +: 8] = newW[b*8 +: 8];
    return res;
  endfunction

  assign sramWrDone = sramWrEn && (waitCnt == waitCfg);
  assign sramRdDone = sramRdEn && (waitCnt == waitCfg);
  assign sramRdata  = mem[sramAddr];

  always @(posedge clk) begin
    if ((sramWrEn || sramRdEn) && !(sramWrDone || sramRdDone)) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
    if (sramWrEn || sramRdEn) enCycles <= enCycles + 1;
    if (sramWrEn && sramWrDone) mem[sramAddr] <= mergeBytes(mem[sramAddr], sramWdata, sramBe);
  end

  typedef struct packed {
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
  } rExp_t;

  logic [1:0] bQ[$];
  rExp_t      rQ[$];
  int totalCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Response monitor: every B/R handshake pops the oldest expectation of its channel.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("enExclusive", {63'd0, sramWrEn & sramRdEn}, 64'd0);
      if (bvalid && bready) begin
        if (bQ.size() == 0) checkOutput("bUnexpected", 64'd1, 64'd0);
        else checkOutput("bresp", {62'd0, bresp}, {62'd0, bQ.pop_front()});
      end
      if (rvalid && rready) begin
        if (rQ.size() == 0) checkOutput("rUnexpected", 64'd1, 64'd0);
        else begin
          rExp_t e;
          e = rQ.pop_front();
          checkOutput("rresp", {62'd0, rresp}, {62'd0, e.resp});
          checkOutput("rdata", {32'd0, rdata}, {32'd0, e.data});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendAw(input logic [ADDR_W-1:0] a);
    logic fire;
    fire = 1'b0;
    awaddr = a;
    awvalid = 1'b1;
    for (int n = 0; n < 50 && !fire; n++) begin
      fire = awready;
      step();
    end
    awvalid = 1'b0;
    if (!fire) checkOutput("awTimeout", 64'd1, 64'd0);
  endtask

  task automatic sendW(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    logic fire;
    fire = 1'b0;
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    for (int n = 0; n < 50 && !fire; n++) begin
      fire = wready;
      step();
    end
    wvalid = 1'b0;
    if (!fire) checkOutput("wTimeout", 64'd1, 64'd0);
  endtask

  task automatic sendAr(input logic [ADDR_W-1:0] a);
    logic fire;
    fire = 1'b0;
    araddr = a;
    arvalid = 1'b1;
    for (int n = 0; n < 50 && !fire; n++) begin
      fire = arready;
      step();
    end
    arvalid = 1'b0;
    if (!fire) checkOutput("arTimeout", 64'd1, 64'd0);
  endtask

  task automatic waitB();
    int n;
    n = 0;
    while (!bvalid && n < 100) begin
      step();
      n++;
    end
    if (!bvalid) checkOutput("bTimeout", 64'd1, 64'd0);
  endtask

  task automatic waitR();
    int n;
    n = 0;
    while (!rvalid && n < 100) begin
      step();
      n++;
    end
    if (!rvalid) checkOutput("rTimeout", 64'd1, 64'd0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic applyStimulus();
    int s;
    int enBase;
    logic ok;

    // Reset values and the first-edge release of the readys
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstAwready", {63'd0, awready}, 64'd0);
    checkOutput("rstWready",  {63'd0, wready},  64'd0);
    checkOutput("rstArready", {63'd0, arready}, 64'd0);
    checkOutput("rstValids",  {62'd0, bvalid, rvalid}, 64'd0);
    checkOutput("rstSramEn",  {62'd0, sramWrEn, sramRdEn}, 64'd0);
    checkOutput("rstRdata",   {32'd0, rdata}, 64'd0);
    #2 rst_n = 1'b1;
    checkOutput("relArreadyPreEdge", {63'd0, arready}, 64'd0);
    step();
    checkOutput("relReadys", {61'd0, awready, wready, arready}, 64'h7);

    // Same-cycle AW+W, zero-wait SRAM, then read back
    bQ.push_back(2'b00);
    fork
      sendAw(32'h10);
      sendW(32'hDEADBEEF, 4'hF);
    join
    checkOutput("t1EnAtT", {63'd0, sramWrEn}, 64'd0);
    step();
    checkOutput("t1WrEn",  {63'd0, sramWrEn}, 64'd1);
    checkOutput("t1Addr",  {54'd0, sramAddr}, 64'd4);
    checkOutput("t1Be",    {60'd0, sramBe}, 64'hF);
    checkOutput("t1Wdata", {32'd0, sramWdata}, 64'hDEADBEEF);
    checkOutput("t1BvalidT1", {63'd0, bvalid}, 64'd0);
    step();
    checkOutput("t1BvalidT2", {63'd0, bvalid}, 64'd1);
    step();
    rQ.push_back('{resp: 2'b00, data: 32'hDEADBEEF});
    sendAr(32'h10);
    step();
    checkOutput("t1RdEn", {63'd0, sramRdEn}, 64'd1);
    waitR();
    step();

    // W three cycles ahead of AW, four SRAM wait cycles, partial strobes
    waitCfg = 4;
    bQ.push_back(2'b00);
    sendW(32'h12345678, 4'h3);
    enBase = enCycles;
    repeat (3) step();
    checkOutput("t2NoEarlyAcc", enCycles, enBase);
    sendAw(32'h20);
    s = 0;
    while (!sramWrEn && s < 20) begin
      step();
      s++;
    end
    checkOutput("t2EnLatency", s, 1);
    checkOutput("t2Be",   {60'd0, sramBe}, 64'h3);
    checkOutput("t2Addr", {54'd0, sramAddr}, 64'd8);
    s = 0;
    while (!bvalid && s < 20) begin
      step();
      s++;
    end
    checkOutput("t2BvalidLatency", s, 5);
    step();
    rQ.push_back('{resp: 2'b00, data: 32'h00005678});
    sendAr(32'h20);
    waitR();
    step();
    waitCfg = 0;

    // Arbitration: ties after reset go WRITE, then READ, alternating
    applyReset();
    bQ.push_back(2'b00);
    rQ.push_back('{resp: 2'b00, data: 32'hDEADBEEF});
    fork
      sendAw(32'h30);
      sendW(32'hA5A5A5A5, 4'hF);
      sendAr(32'h10);
    join
    step();
    checkOutput("t3Tie1Write", {62'd0, sramWrEn, sramRdEn}, 64'b10);
    waitR();
    step();
    bQ.push_back(2'b00);
    rQ.push_back('{resp: 2'b00, data: 32'hA5A5A5A5});
    fork
      sendAw(32'h34);
      sendW(32'h11223344, 4'hF);
      sendAr(32'h30);
    join
    step();
    checkOutput("t3Tie2Write", {62'd0, sramWrEn, sramRdEn}, 64'b10);
    waitR();
    step();
    bQ.push_back(2'b00);
    fork
      sendAw(32'h38);
      sendW(32'h0BADCAFE, 4'hF);
    join
    waitB();
    step();
    bQ.push_back(2'b00);
    rQ.push_back('{resp: 2'b00, data: 32'h11223344});
    fork
      sendAw(32'h3C);
      sendW(32'h00000077, 4'hF);
      sendAr(32'h34);
    join
    step();
    checkOutput("t3Tie3Read", {62'd0, sramWrEn, sramRdEn}, 64'b01);
    waitB();
    step();

    // Out-of-window write/read and a zero-strobe write
    enBase = enCycles;
    bQ.push_back(2'b10);
    fork
      sendAw(32'h1000);
      sendW(32'h55555555, 4'hF);
    join
    step();
    checkOutput("t4BvalidT1", {63'd0, bvalid}, 64'd1);
    checkOutput("t4Bresp", {62'd0, bresp}, 64'b10);
    step();
    rQ.push_back('{resp: 2'b10, data: 32'h0});
    sendAr(32'h1000);
    step();
    checkOutput("t4RvalidT1", {63'd0, rvalid}, 64'd1);
    step();
    checkOutput("t4NoSramAcc", enCycles, enBase);
    bQ.push_back(2'b00);
    fork
      sendAw(32'h40);
      sendW(32'hFFFFFFFF, 4'h0);
    join
    step();
    checkOutput("t4Strb0BvalidT1", {63'd0, bvalid}, 64'd1);
    step();
    checkOutput("t4Strb0NoAcc", enCycles, enBase);
    rQ.push_back('{resp: 2'b00, data: 32'h0});
    sendAr(32'h40);
    waitR();
    step();

    // Back-pressure on B then R for ten cycles
    bready = 1'b0;
    bQ.push_back(2'b00);
    fork
      sendAw(32'h44);
      sendW(32'hCAFEF00D, 4'hF);
    join
    waitB();
    ok = 1'b1;
    repeat (10) begin
      step();
      if (!(bvalid && bresp == 2'b00 && !awready && !wready)) ok = 1'b0;
    end
    checkOutput("t5BStall", {63'd0, ok}, 64'd1);
    bready = 1'b1;
    step();
    step();
    rready = 1'b0;
    rQ.push_back('{resp: 2'b00, data: 32'hCAFEF00D});
    sendAr(32'h44);
    waitR();
    ok = 1'b1;
    repeat (10) begin
      step();
      if (!(rvalid && rresp == 2'b00 && rdata == 32'hCAFEF00D && !arready)) ok = 1'b0;
    end
    checkOutput("t5RStall", {63'd0, ok}, 64'd1);
    rready = 1'b1;
    step();
    step();

    // Reset asserted in the middle of a read access
    waitCfg = 8;
    sendAr(32'h10);
    step();
    checkOutput("t6RdEnBefore", {63'd0, sramRdEn}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6RdEnAsync", {63'd0, sramRdEn}, 64'd0);
    checkOutput("t6ArreadyInRst", {63'd0, arready}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    checkOutput("t6ArreadyAfter", {63'd0, arready}, 64'd1);
    ok = 1'b1;
    repeat (12) begin
      step();
      if (rvalid) ok = 1'b0;
    end
    checkOutput("t6NoRvalid", {63'd0, ok}, 64'd1);
    waitCfg = 0;

    checkOutput("bQueueEmpty", bQ.size(), 0);
    checkOutput("rQueueEmpty", rQ.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = '0;
    applyStimulus();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
